// File: rtl/axi4_lite_lstm_cfg_slave.sv
// ---------------------------------------------------------------------------
// axi4_lite_lstm_cfg_slave
//
// AXI4-Lite slave that owns the LSTM weight store and the control/status
// registers, and drives the LSTM layer core.
//
// Address map (byte addresses; the low BW bits are ignored):
//   addr[31]=0 : weight region, word index = {layer, gate, idx}
//   addr[31]=1 : control region, word 0 = CTRL (wo), 1 = STATUS (ro), 2 = ID (ro)
//   Anything outside those returns SLVERR and changes no state.
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-low reset
//   i_aw*/o_awready               write address channel (prot ignored)
//   i_w*/o_wready                 write data channel with byte strobes
//   o_bresp/o_bvalid/i_bready     write response channel
//   i_ar*/o_arready               read address channel (prot ignored)
//   o_rdata/o_rresp/o_rvalid/i_rready  read data channel
//   i_core_rd_en/layer/gate/addr  core-side weight read request
//   o_core_rdata                  core read data, one cycle after request
//   o_core_start                  one-cycle start pulse to the core
//   i_core_busy, i_core_done      core busy level and completion pulse
//
// Handshake rules: every channel transfers on a cycle where valid and ready
// are both high at the rising clock edge. A valid, once raised by this block,
// stays high with stable payload until the matching ready is seen.
// ---------------------------------------------------------------------------
module axi4_lite_lstm_cfg_slave #(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 512,
   parameter  int LAYERS     = 2,
   localparam int AW         = $clog2(DEPTH),
   localparam int LW         = (LAYERS > 1) ? $clog2(LAYERS) : 1,
   localparam int NB         = DATA_WIDTH / 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [31:0]           i_awaddr,
   input  logic [2:0]            i_awprot,
   input  logic                  i_awvalid,
   output logic                  o_awready,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [NB-1:0]         i_wstrb,
   input  logic                  i_wvalid,
   output logic                  o_wready,
   output logic [1:0]            o_bresp,
   output logic                  o_bvalid,
   input  logic                  i_bready,
   input  logic [31:0]           i_araddr,
   input  logic [2:0]            i_arprot,
   input  logic                  i_arvalid,
   output logic                  o_arready,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic [1:0]            o_rresp,
   output logic                  o_rvalid,
   input  logic                  i_rready,
   input  logic                  i_core_rd_en,
   input  logic [LW-1:0]         i_core_layer,
   input  logic [1:0]            i_core_gate,
   input  logic [AW-1:0]         i_core_addr,
   output logic [DATA_WIDTH-1:0] o_core_rdata,
   output logic                  o_core_start,
   input  logic                  i_core_busy,
   input  logic                  i_core_done
);

   localparam int WEIGHTS = 4;
   localparam int BW      = $clog2(DATA_WIDTH / 8);
   localparam int LSB_L   = BW + AW + 2;        // lowest bit of the layer field
   localparam int TOP     = BW + AW + 2 + LW;   // first bit above the layer field
   localparam int IW      = LW + 2 + AW;        // flat word index width
   localparam int NWORDS  = LAYERS * WEIGHTS * DEPTH;
   localparam logic [31:0] ID_VAL = {8'(LAYERS), 8'(WEIGHTS), 16'(DEPTH)};

   typedef struct packed {
      logic          err;    // address is not mapped -> SLVERR
      logic          ctrl;   // control region
      logic [1:0]    off;    // control word offset
      logic [IW-1:0] widx;   // {layer, gate, idx} for the weight region
   } dec_t;

   function automatic dec_t decode(input logic [31:BW] a);
      dec_t       d;
      logic [8:0] layer_ext;
      d         = '0;
      layer_ext = 9'(a[TOP-1:LSB_L]);
      d.ctrl    = a[31];
      d.off     = a[BW+1:BW];
      d.widx    = a[TOP-1:BW];
      if (a[31]) begin
         d.err = (|a[30:BW+2]) || (a[BW+1:BW] == 2'd3);
      end else begin
         d.err = (|a[30:TOP]) || (layer_ext >= 9'(LAYERS));
      end
      return d;
   endfunction

   // Weight store; intentionally not reset.
   logic [DATA_WIDTH-1:0] r_mem [NWORDS];

   logic                  r_aw_held;
   logic [31:BW]          r_aw_addr;
   logic                  r_w_held;
   logic [DATA_WIDTH-1:0] r_w_data;
   logic [NB-1:0]         r_w_strb;
   logic                  r_bvalid;
   logic [1:0]            r_bresp;
   logic                  r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;
   logic [DATA_WIDTH-1:0] r_core_rdata;
   logic                  r_core_start;
   logic                  r_done;

   dec_t                  w_wr;
   dec_t                  w_rd;
   logic                  w_commit;
   logic                  w_ctrl_wr;
   logic                  w_start;
   logic                  w_clear;
   logic                  w_mem_wr;
   logic                  w_ar_hs;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic [IW-1:0]         w_core_idx;
   logic                  w_core_ok;
   logic                  w_unused;

   assign w_wr = decode(r_aw_addr);
   assign w_rd = decode(i_araddr[31:BW]);

   assign o_awready    = !r_aw_held && !r_bvalid;
   assign o_wready     = !r_w_held && !r_bvalid;
   assign o_arready    = !r_rvalid;
   assign o_bvalid     = r_bvalid;
   assign o_bresp      = r_bresp;
   assign o_rvalid     = r_rvalid;
   assign o_rdata      = r_rdata;
   assign o_rresp      = r_rresp;
   assign o_core_rdata = r_core_rdata;
   assign o_core_start = r_core_start;

   // Commit happens on the first edge where both halves are held and no
   // response is outstanding; bvalid then blocks a second commit.
   assign w_commit  = r_aw_held && r_w_held && !r_bvalid;
   // CTRL writes without byte 0 enabled are accepted but have no effect.
   assign w_ctrl_wr = w_commit && w_wr.ctrl && !w_wr.err && (w_wr.off == 2'd0) && r_w_strb[0];
   assign w_start   = w_ctrl_wr && r_w_data[0] && !i_core_busy;
   assign w_clear   = w_start || (w_ctrl_wr && r_w_data[1]);
   assign w_mem_wr  = w_commit && !w_wr.ctrl && !w_wr.err;
   assign w_ar_hs   = i_arvalid && !r_rvalid;

   assign w_core_idx = {i_core_layer, i_core_gate, i_core_addr};
   assign w_core_ok  = 9'(i_core_layer) < 9'(LAYERS);

   always_comb begin
      w_rd_data = '0;
      if (!w_rd.err) begin
         if (!w_rd.ctrl) begin
            w_rd_data = r_mem[w_rd.widx];
         end else begin
            case (w_rd.off)
               2'd1:    w_rd_data = DATA_WIDTH'({r_done, i_core_busy});
               2'd2:    w_rd_data = DATA_WIDTH'(ID_VAL);
               default: w_rd_data = '0;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_aw_held    <= 1'b0;
         r_aw_addr    <= '0;
         r_w_held     <= 1'b0;
         r_w_data     <= '0;
         r_w_strb     <= '0;
         r_bvalid     <= 1'b0;
         r_bresp      <= 2'b00;
         r_rvalid     <= 1'b0;
         r_rdata      <= '0;
         r_rresp      <= 2'b00;
         r_core_rdata <= '0;
         r_core_start <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         if (i_awvalid && o_awready) begin
            r_aw_held <= 1'b1;
            r_aw_addr <= i_awaddr[31:BW];
         end
         if (i_wvalid && o_wready) begin
            r_w_held <= 1'b1;
            r_w_data <= i_wdata;
            r_w_strb <= i_wstrb;
         end
         if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr.err ? 2'b10 : 2'b00;
         end
         if (r_bvalid && i_bready) begin
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end

         if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd.err ? 2'b10 : 2'b00;
         end else if (r_rvalid && i_rready) begin
            r_rvalid <= 1'b0;
         end

         // Reads see the pre-write contents when a commit hits the same word.
         if (i_core_rd_en) begin
            r_core_rdata <= w_core_ok ? r_mem[w_core_idx] : '0;
         end

         r_core_start <= w_start;

         // A completion in the same cycle as a clear leaves done set.
         if (i_core_done) begin
            r_done <= 1'b1;
         end else if (w_clear) begin
            r_done <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_mem_wr) begin
         for (int b = 0; b < NB; b++) begin
            if (r_w_strb[b]) begin
               r_mem[w_wr.widx][b*8 +: 8] <= r_w_data[b*8 +: 8];
            end
         end
      end
   end

   // Protection bits and sub-word address bits carry no meaning here.
   assign w_unused = &{1'b0, i_awprot, i_arprot, i_awaddr[BW-1:0], i_araddr[BW-1:0]};

endmodule

// File: doc/axi4_lite_lstm_cfg_slave.md
Name: axi4_lite_lstm_cfg_slave

Overview:
- Parametrised AXI4-Lite slave that owns the LSTM weight store and the control/status registers, and drives the layer core.
- Generalises the current wrapper in four ways: data width, layer count, byte strobes, and SLVERR decoding of out-of-range addresses.
- Adds a start/busy/done control path and a dedicated core-side read port into the weight store.
- Sits between the host interconnect and the LSTM layer datapath.

Parameters:
- DATA_WIDTH, 32, AXI data width and weight width; 32 or 64 only.
- DEPTH, 512, words per (layer, gate) bank; power of two.
- LAYERS, 2, number of layers; 1..255.
- WEIGHTS (localparam), 4, gates per layer.
- AW (localparam), $clog2(DEPTH).
- LW (localparam), max(1, $clog2(LAYERS)).
- BW (localparam), $clog2(DATA_WIDTH/8).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- awaddr  in  32  write address
- awprot  in  3  ignored
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response, OKAY=00 or SLVERR=10
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  32  read address
- arprot  in  3  ignored
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response, OKAY=00 or SLVERR=10
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- core_rd_en  in  1  core weight read strobe
- core_layer  in  LW  core layer select
- core_gate  in  2  core gate select
- core_addr  in  AW  core word index
- core_rdata  out  DATA_WIDTH  core read data
- core_start  out  1  one-cycle start pulse to the core
- core_busy  in  1  core busy level
- core_done  in  1  core completion pulse

Behaviour:

Reset (rst=0, asynchronous):
- awready=1, wready=1, arready=1.
- bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0, core_rdata=0, core_start=0.
- Done flag cleared; held address and held data discarded.
- Weight array is not reset.
- Reset mid-transaction aborts that transaction; no response is issued.

Address decode (byte address, low BW bits ignored):
- awaddr[31]=0 selects the weight region: idx=a[BW+AW-1:BW], gate=next 2 bits, layer=next LW bits.
- SLVERR if layer>=LAYERS, or if any bit above the layer field up to bit 30 is nonzero.
- awaddr[31]=1 selects the control region. Word offset 0 = CTRL, 1 = STATUS, 2 = ID.
- Any other control offset, or any nonzero bit in [30:BW+2], returns SLVERR.

Write channel:
- AW and W are accepted independently, one-entry hold each.
- awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
- The cycle after both are held, the write commits and bvalid=1 with bresp.
- bvalid holds until bready; both holds clear on the B handshake.
- Weight writes update only bytes with wstrb set.
- A SLVERR write changes no state.

Read channel:
- An AR handshake at cycle T gives rvalid=1 at T+1, with rdata/rresp registered.
- rdata/rresp are held stable until rready.
- arready = !rvalid; maximum rate is one read per 2 cycles.
- SLVERR reads return rdata=0.

Registers:
- CTRL (write-only, reads 0):
  - Requires wstrb[0].
  - bit0=1 pulses core_start for exactly one cycle, the cycle after commit, only if core_busy=0; otherwise ignored with bresp OKAY.
  - bit1=1 clears done.
  - A start also clears done.
- STATUS (read-only; writes return OKAY and are ignored):
  - bit0 = core_busy, bit1 = done.
  - done is sticky, set by core_done.
  - If core_done and a clear occur in the same cycle, set wins.
- ID (read-only): {LAYERS[7:0], WEIGHTS[7:0], DEPTH[15:0]}, zero-extended; default 0x02040200.

Core port:
- core_rd_en at cycle T gives core_rdata at T+1; core_rdata is held otherwise.
- Independent of AXI reads.
- A core read and an AXI write to the same word in the same cycle returns the old data.
- A core read with layer>=LAYERS returns 0.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x3014 (layer1/gate2/idx5) with wstrb=F → bresp=00. Read 0x3014 → rdata=0xDEADBEEF, rresp=00. core_rd_en with (1,2,5) → core_rdata=0xDEADBEEF at the next cycle.
- Write 0x11223344 to 0x3014 with wstrb=0101 → read returns 0xDE22BE44.
- AW presented 3 cycles before W, and separately W before AW → exactly one write and one bvalid each. Hold bready=0 for 4 cycles → bvalid stays 1 and awready=wready=0.
- Write and read 0x4000 (layer 2 with LAYERS=2) → bresp=10, rresp=10, rdata=0, array unchanged. Read 0x8000000C → SLVERR. Read 0x80000008 → 0x02040200.
- Write CTRL=1 with core_busy=0 → a single-cycle core_start. Repeat with core_busy=1 → no pulse. core_done pulse → STATUS=0x2. core_done coincident with a CTRL=2 write → done remains 1.
- Assert rst mid-read, between AR handshake and rvalid → rvalid=0 and arready=1 after release. The weight written earlier still reads back 0xDE22BE44.
